// File: rtl/a2s_pkg.sv
// Shared types and AXI read-burst constants for the OCM-to-stream read controller.
package a2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int unsigned BURST_LEN    = 16;
    localparam logic [3:0]  ARLEN_BURST  = 4'(BURST_LEN - 1);
    localparam logic [3:0]  LAST_BEAT    = 4'(BURST_LEN - 1);
    localparam logic [2:0]  ARSIZE_4B    = 3'b010;
    localparam logic [1:0]  ARBURST_INCR = 2'b01;
    localparam logic [1:0]  OKAY         = 2'b00;

    // Byte address of a 64-byte block inside the OCM ring.
    function automatic logic [31:0] blk_addr(input logic [31:0] base,
                                             input logic [31:0] mask,
                                             input logic [31:0] blk);
        return (base & ~mask) | ((blk << 6) & mask);
    endfunction

endpackage

// File: rtl/a2s_controller.sv
// Fetches 16-word OCM blocks over AXI read into a 32-word ping-pong buffer
// and exposes the buffer read address to the stream consumer.
module a2s_controller
    import a2s_pkg::*;
#(
    parameter logic [31:0] ocm_haddr = 32'hfffc0000,
    parameter int unsigned ocm_width = 16
) (
    input  logic        AXI_clk,
    input  logic        rst_n,
    input  logic        sync,
    input  logic        Oen,
    output logic [4:0]  Oaddr,
    output logic        Ovalid,
    output logic [31:0] a2s_cnt,
    output logic [31:0] AXI_araddr,
    output logic [3:0]  AXI_arlen,
    output logic [2:0]  AXI_arsize,
    output logic [1:0]  AXI_arburst,
    output logic        AXI_arvalid,
    input  logic        AXI_arready,
    input  logic        AXI_rvalid,
    output logic        AXI_rready,
    input  logic        AXI_rlast,
    input  logic [1:0]  AXI_rresp,
    output logic [4:0]  a2s_addr,
    output logic        a2s_en,
    output logic        a2s_underrun,
    output logic        a2s_rerr
);

    localparam logic [31:0] RING_MASK = (ocm_width >= 32) ? 32'hffff_ffff
                                      : 32'((33'd1 << ocm_width) - 33'd1);
    localparam logic [31:0] RING_BASE = ocm_haddr & ~RING_MASK;

    state_t      state, state_nxt;
    logic [35:0] cnt;
    logic [31:0] fblk;
    logic [31:0] ahead;
    logic [1:0]  hv, hv_nxt;
    logic        flush;
    logic [3:0]  beat;
    logic        fetch_ok, beat_acc, last_acc, fill_done, beat_err;

    assign ahead     = fblk - cnt[35:4];
    assign fetch_ok  = (ahead < 32'd2) && !flush;
    assign beat_acc  = AXI_rvalid && AXI_rready;
    assign last_acc  = beat_acc && AXI_rlast;
    assign fill_done = last_acc && !flush;
    assign beat_err  = (AXI_rresp != OKAY)
                    || (AXI_rlast && (beat != LAST_BEAT))
                    || (!AXI_rlast && (beat == LAST_BEAT));

    assign Oaddr       = cnt[4:0];
    assign a2s_cnt     = cnt[35:4];
    assign Ovalid      = hv[cnt[4]];
    assign a2s_addr    = {fblk[0], beat};
    assign a2s_en      = beat_acc && !flush;
    assign AXI_arlen   = ARLEN_BURST;
    assign AXI_arsize  = ARSIZE_4B;
    assign AXI_arburst = ARBURST_INCR;

    always_ff @(posedge AXI_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and half-valid update; sync blocks a new fetch in the same cycle.
    always_comb begin
        state_nxt = state;
        hv_nxt    = hv;
        case (state)
            IDLE:    if (!sync && fetch_ok)            state_nxt = ADDR;
            ADDR:    if (AXI_arvalid && AXI_arready)   state_nxt = DATA;
            DATA:    if (last_acc)                     state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
        if (Oen && (cnt[3:0] == 4'hf)) hv_nxt[cnt[4]]  = 1'b0;
        if (fill_done)                 hv_nxt[fblk[0]] = 1'b1;
    end

    // AXI handshake outputs follow the next state so they are clean flops.
    always_ff @(posedge AXI_clk or negedge rst_n) begin
        if (!rst_n) begin
            AXI_arvalid <= 1'b0;
            AXI_rready  <= 1'b0;
            AXI_araddr  <= RING_BASE;
            beat        <= 4'd0;
            flush       <= 1'b0;
        end else begin
            AXI_arvalid <= (state_nxt == ADDR);
            AXI_rready  <= (state_nxt == DATA);
            if (state == IDLE && state_nxt == ADDR)
                AXI_araddr <= blk_addr(ocm_haddr, RING_MASK, fblk);
            if (state != DATA)  beat <= 4'd0;
            else if (beat_acc)  beat <= beat + 4'd1;
            if (sync && state != IDLE && state_nxt != IDLE) flush <= 1'b1;
            else if (state_nxt == IDLE)                     flush <= 1'b0;
        end
    end

    // Stream/fetch counters and sticky flags; sync wins over everything else.
    always_ff @(posedge AXI_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 36'd0;
            fblk         <= 32'd0;
            hv           <= 2'b00;
            a2s_underrun <= 1'b0;
            a2s_rerr     <= 1'b0;
        end else if (sync) begin
            cnt          <= 36'd0;
            fblk         <= 32'd0;
            hv           <= 2'b00;
            a2s_underrun <= 1'b0;
            a2s_rerr     <= 1'b0;
        end else begin
            if (Oen)                  cnt  <= cnt + 36'd1;
            if (fill_done)            fblk <= fblk + 32'd1;
            hv <= hv_nxt;
            if (Oen && !hv[cnt[4]])   a2s_underrun <= 1'b1;
            if (beat_acc && beat_err) a2s_rerr     <= 1'b1;
        end
    end

endmodule
